// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM output stage and the SPI register block
// that feeds it.
package pwm_pkg;

    localparam int PWM_BITS = 8;
    localparam int NUM_PINS = 16;

    localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;

    // Register addresses as decoded by the upstream SPI register block.
    localparam logic [7:0] ADDR_EN_OUT_7_0  = 8'd1;
    localparam logic [7:0] ADDR_EN_OUT_15_8 = 8'd2;
    localparam logic [7:0] ADDR_EN_PWM_7_0  = 8'd3;
    localparam logic [7:0] ADDR_EN_PWM_15_8 = 8'd4;
    localparam logic [7:0] ADDR_DUTY        = 8'd5;

    typedef enum logic [1:0] {
        PIN_OFF = 2'd0,
        PIN_ON  = 2'd1,
        PIN_PWM = 2'd2
    } pin_mode_e;

    // The output-enable bit dominates; the PWM bit only matters on an enabled pin.
    function automatic pin_mode_e pin_mode(input logic en_out, input logic en_pwm);
        if (!en_out)
            return PIN_OFF;
        else if (!en_pwm)
            return PIN_ON;
        else
            return PIN_PWM;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running divide-by-PRESCALE counter; step marks the last cycle of each
// division and advances the PWM counter.
module pwm_prescaler #(
    parameter int PRESCALE = 13
) (
    input  logic clk,
    input  logic rst_n,
    output logic step
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] prescale_cnt;

    // With PRESCALE == 1 the counter sits at 0 and step is permanently high.
    assign step = (prescale_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prescale_cnt <= '0;
        else if (step)
            prescale_cnt <= '0;
        else
            prescale_cnt <= prescale_cnt + 1'b1;
    end

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 pins as off, static-on or PWM at a common, period-aligned duty
// cycle taken from the SPI configuration registers.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [PWM_BITS-1:0] pwm_duty_cycle,
    output logic [NUM_PINS-1:0] out,
    output logic                period_start
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic                step;
    logic                period_end;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_shadow;
    logic                pwm_level;
    logic [NUM_PINS-1:0] en_out;
    logic [NUM_PINS-1:0] en_pwm;
    logic [NUM_PINS-1:0] out_next;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step)
    );

    assign en_out     = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm     = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign period_end = step && (pwm_cnt == CNT_MAX);

    // Full scale is special-cased so 0xFF means truly always-on, not 255/256.
    assign pwm_level  = (duty_shadow == DUTY_FULL) || (pwm_cnt < duty_shadow);

    // NOTE: combinational logic assigns every output a default first, so no
    // path through the block leaves a value held and no latch is inferred.
    always_comb begin
        out_next = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            case (pin_mode(en_out[i], en_pwm[i]))
                PIN_ON:  out_next[i] = 1'b1;
                PIN_PWM: out_next[i] = pwm_level;
                default: out_next[i] = 1'b0;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; blocking here would let pwm_cnt's new value leak
    // into the duty-shadow and period_start decisions on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt      <= '0;
            duty_shadow  <= '0;
            period_start <= 1'b0;
            out          <= '0;
        end else begin
            if (step)
                pwm_cnt <= pwm_cnt + 1'b1;
            // Duty is only sampled at the wrap so a period is never cut short.
            if (period_end)
                duty_shadow <= pwm_duty_cycle;
            period_start <= period_end;
            out          <= out_next;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: vector table, directed period
// measurements and randomized traffic against a cycle-count reference model.
module tb_pwm_peripheral;

    localparam int P      = 13;
    localparam int PERIOD = 256 * P;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] en_out = '0;
    logic [15:0] en_pwm = '0;
    logic [7:0]  duty   = '0;
    logic [15:0] out;
    logic        period_start;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(
        .PRESCALE (P)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the PWM period follows from the number of
    // clock edges since reset; duty is latched once per 256*P edges.
    int unsigned t        = 0;
    logic [7:0]  m_shadow = '0;
    logic [15:0] exp_out  = '0;
    logic        exp_ps   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int  cnt;
        logic lvl;
        if (!rst_n) begin
            t        = 0;
            m_shadow = '0;
            exp_out  = '0;
            exp_ps   = 1'b0;
        end else begin
            cnt = (t / P) % 256;
            lvl = (m_shadow == 8'hFF) || (cnt < int'(m_shadow));
            for (int i = 0; i < 16; i++) begin
                if (!en_out[i])      exp_out[i] = 1'b0;
                else if (!en_pwm[i]) exp_out[i] = 1'b1;
                else                 exp_out[i] = lvl;
            end
            exp_ps = ((t + 1) % PERIOD) == 0;
            if (exp_ps) m_shadow = duty;
            t++;
        end
    end

    always @(negedge clk) begin
        check("model_out", 32'(out), 32'(exp_out));
        check("model_period_start", 32'(period_start), 32'(exp_ps));
    end

    // Samples from the current negedge up to and including the next
    // period_start; with the one-cycle output latency that window covers
    // exactly counts 0..255 of one period.
    task automatic measure(input int change_at, input logic [7:0] change_val,
                           output int len, output int highs,
                           output logic [15:0] and_v, output logic [15:0] or_v);
        len   = 0;
        highs = 0;
        and_v = '1;
        or_v  = '0;
        for (int k = 0; k < PERIOD + 100; k++) begin
            @(negedge clk);
            len++;
            if (out[0]) highs++;
            and_v &= out;
            or_v  |= out;
            if (len == change_at) duty = change_val;
            if (period_start) return;
        end
        check("period_start_timeout", 32'(len), 32'(PERIOD));
    endtask

    typedef struct {
        string       name;
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [7:0]  duty;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          len;
        int          highs;
        logic [15:0] and_v;
        logic [15:0] or_v;

        // Applied during the first period, while the duty shadow is still 0.
        vecs[0] = '{"en_low_static",   16'h00FF, 16'h0000, 8'hAA, 16'h00FF};
        vecs[1] = '{"en_high_static",  16'hFF00, 16'h0000, 8'hFF, 16'hFF00};
        vecs[2] = '{"pwm_first_period",16'hFFFF, 16'hFFFF, 8'hFF, 16'h0000};
        vecs[3] = '{"mixed_modes",     16'hFFFF, 16'h0F0F, 8'h80, 16'hF0F0};
        vecs[4] = '{"pattern_static",  16'h1234, 16'h0000, 8'h00, 16'h1234};
        vecs[5] = '{"pwm_without_en",  16'h0000, 16'hFFFF, 8'hFF, 16'h0000};
        vecs[6] = '{"pwm_sel_low",     16'hA5A5, 16'h00FF, 8'h10, 16'hA500};

        #1 rst_n = 1'b0;
        #2;
        check("reset_out", 32'(out), 32'h0);
        check("reset_period_start", 32'(period_start), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            en_out = vecs[i].en_out;
            en_pwm = vecs[i].en_pwm;
            duty   = vecs[i].duty;
            @(negedge clk);
            check(vecs[i].name, 32'(out), 32'(vecs[i].exp_out));
        end

        // First period after reset: PWM pins low, boundary at 256*P edges.
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'h80;
        measure(-1, 8'h00, len, highs, and_v, or_v);
        check("first_period_len", 32'(len), 32'(PERIOD - $size(vecs)));
        check("first_period_pwm_low", 32'(or_v), 32'h0);

        measure(-1, 8'h00, len, highs, and_v, or_v);
        check("duty80_period_len", 32'(len), 32'(PERIOD));
        check("duty80_high_clks", 32'(highs), 32'(128 * P));
        check("duty80_all_toggle_hi", 32'(or_v), 32'hFFFF);
        check("duty80_all_toggle_lo", 32'(and_v), 32'h0);

        duty = 8'h00;
        measure(-1, 8'h00, len, highs, and_v, or_v);
        check("duty_still_buffered", 32'(highs), 32'(128 * P));

        duty = 8'hFF;
        measure(-1, 8'h00, len, highs, and_v, or_v);
        check("duty00_never_high", 32'(or_v), 32'h0);

        duty = 8'h40;
        measure(-1, 8'h00, len, highs, and_v, or_v);
        check("dutyff_never_low", 32'(and_v), 32'hFFFF);
        check("dutyff_high_clks", 32'(highs), 32'(PERIOD));

        // Duty rewritten at pwm_cnt == 100: current period keeps 0x40.
        measure(100 * P, 8'hC0, len, highs, and_v, or_v);
        check("midperiod_keeps_old", 32'(highs), 32'(64 * P));

        duty   = 8'h40;
        en_pwm = 16'h5555;
        measure(-1, 8'h00, len, highs, and_v, or_v);
        check("new_duty_next_period", 32'(highs), 32'(192 * P));
        check("odd_pins_static_on", 32'(and_v & 16'hAAAA), 32'hAAAA);

        measure(-1, 8'h00, len, highs, and_v, or_v);
        check("duty40_even_pins", 32'(highs), 32'(64 * P));
        check("duty40_odd_pins", 32'(and_v & 16'hAAAA), 32'hAAAA);

        @(negedge clk);
        check("pin0_pwm_high", 32'(out), 32'hFFFF);
        en_out = 16'hFFFE;
        @(negedge clk);
        check("pin0_disabled_next_clk", 32'(out), 32'hFFFE);

        // Asynchronous reset in the middle of an active period.
        repeat (500) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_out", 32'(out), 32'h0);
        check("midreset_period_start", 32'(period_start), 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'h80;
        measure(-1, 8'h00, len, highs, and_v, or_v);
        check("post_reset_period_len", 32'(len), 32'(PERIOD));
        check("post_reset_pwm_low", 32'(or_v), 32'h0);

        // Randomized traffic, checked every cycle by the reference model.
        for (int r = 0; r < 40; r++) begin
            en_out = 16'($urandom);
            en_pwm = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       duty = 8'h00;
                1:       duty = 8'hFF;
                default: duty = 8'($urandom);
            endcase
            repeat ($urandom_range(20, 250)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
